digit_scan_mux: RTL and testbench
=================================

Name: digit_scan_mux

Overview:
Time-multiplexed scan driver for the clock's multi-digit 7-segment display. It sits directly upstream of the per-digit BCD-to-segment decoder.
- Takes all BCD digits in parallel and a per-digit enable mask.
- Presents one digit at a time on a 4-bit data bus with the matching active-low anode select.
- Inserts dead time between digits against ghosting.
- Snapshots inputs once per frame so no display tearing occurs.

Parameters:
CLK_FREQ_HZ, 100000000, input clock frequency
SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_FREQ_HZ/SCAN_HZ clocks per digit slot
NUM_DIGITS, 8, digits scanned, legal range 2..8
DEAD_CYCLES, 16, clocks at start of each slot with all anodes off; must satisfy DIV >= DEAD_CYCLES+2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
digits_in  input  4*NUM_DIGITS  BCD digits; digit i at [4i+3:4i]; digit 0 rightmost
digit_en  input  NUM_DIGITS  1 = digit i shown, 0 = blanked
data  output  4  digit value to decoder; 4'hF = blank code
an_n  output  NUM_DIGITS  anode select, active low, at most one bit low
frame_tick  output  1  one-clock pulse on the edge where slot index wraps to 0

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low; assertion takes effect immediately, deassertion is sampled by clk.
- Reset values:
  - cnt=0, idx=0.
  - data=4'hF, an_n=all ones, frame_tick=0.
  - shadow digits=all 4'hF, shadow enable=all 0, init flag=0.
- Prescaler:
  - cnt counts 0..DIV-1, width $clog2(DIV).
  - At cnt==DIV-1: cnt<=0 and idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Snapshot:
  - Shadow registers load digits_in/digit_en on the first clock after reset release (init flag 0->1).
  - They also load on every edge where cnt==DIV-1 && idx==NUM_DIGITS-1.
  - Input changes mid-frame never reach outputs until the next frame.
- Outputs: registered, computed from next-state, so they change on the same edge as idx/cnt.
  - data = shadow digit[idx] if shadow_en[idx], else 4'hF.
  - an_n = all ones while cnt < DEAD_CYCLES.
  - Otherwise an_n = ~(1<<idx) if shadow_en[idx], else all ones.
  - frame_tick = 1 for exactly the one cycle after the wrap edge (idx==0, cnt==0), except the first slot after reset.
- Data width rule: digit values 10..15 pass through unchanged; the decoder blanks them.
- Boundaries:
  - All digits disabled: an_n stays all ones and data=4'hF; the scan continues.
  - Simultaneous input change and snapshot edge: the value sampled on that edge is captured.
  - Reset mid-slot: outputs go to reset values immediately, asynchronously; the scan restarts at idx 0, cnt 0, and a fresh snapshot loads after release.
- Dwell: each digit is lit for exactly DIV-DEAD_CYCLES clocks per frame. Frame period = NUM_DIGITS*DIV clocks.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Evaluated on the shadow values at load time.
  - Digit i (i>=1) is treated as disabled when its shadow value is 0 and every enabled higher digit is also 0 or disabled.
  - Digit 0 is never suppressed, so "00000000" shows as a single "0".
- Undefined: only digit_en controls blanking, and zeros are displayed.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, SCAN_HZ=100 (DIV=10), NUM_DIGITS=8, DEAD_CYCLES=2.
- Reset then release, digits_in=32'h12345678, digit_en=8'hFF -> slot 0: an_n=8'hFF for 2 clocks, then 8'hFE with data=8 for 8 clocks. Slot 1: data=7, an_n=8'hFD. Pattern continues to idx 7 (data=1, an_n=8'h7F); frame_tick pulses every 80 clocks.
- Change digits_in to 32'h99999999 during idx 3 -> remaining slots 4..7 still show 4,3,2,1. From the next frame_tick, all slots show 9.
- digit_en=8'b0000_0101 -> only slots 0 and 2 assert an anode. Other slots have an_n=8'hFF and data=4'hF.
- Assert rst_n=0 mid-slot (idx=5, cnt=6) -> an_n=8'hFF and data=4'hF in the same cycle without a clock edge. After release, the scan restarts from idx 0.
- Over one full frame, check that at most one an_n bit is low in every cycle, and that each enabled digit is low for exactly 8 clocks.
- With LEADING_ZERO_BLANK_EN, digits_in=32'h00012034 -> slots 5..7 blanked (an_n=FF, data=F). Slots 0..4 show 4,3,0,2,1, so the interior zero is shown. digits_in=0 -> only slot 0 lit, showing 0.

Source files
------------

// File: rtl/digit_scan_mux_if.sv
// ----------------------------------------------------------------------------
// digit_scan_mux_if
//
// Bundles the parallel digit inputs and the scanned display outputs of
// digit_scan_mux.
//
// Signals:
//   digits_in  [4*NUM_DIGITS-1:0]  BCD digits, digit i at [4i+3:4i], digit 0 rightmost
//   digit_en   [NUM_DIGITS-1:0]    1 = digit i shown, 0 = blanked
//   data       [3:0]               current digit value to decoder, 4'hF = blank
//   an_n       [NUM_DIGITS-1:0]    anode select, active low, at most one bit low
//   frame_tick                     one-clock pulse after the slot index wraps to 0
//
// Modports:
//   master : producer of digits, consumer of the scan outputs
//   slave  : the scan driver itself
// ----------------------------------------------------------------------------
interface digit_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              data;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_tick;

    modport master (
        output digits_in, digit_en,
        input  data, an_n, frame_tick
    );

    modport slave (
        input  digits_in, digit_en,
        output data, an_n, frame_tick
    );
endinterface

// File: rtl/digit_scan_mux.sv
// ----------------------------------------------------------------------------
// digit_scan_mux
//
// Time-multiplexed scan driver for a multi-digit 7-segment display. Each digit
// gets a slot of DIV = CLK_FREQ_HZ/SCAN_HZ clocks; the first DEAD_CYCLES clocks
// of every slot keep all anodes off against ghosting. Inputs are captured into
// shadow registers once per frame so a frame never mixes old and new values.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    digit_scan_mux_if.slave (digits_in, digit_en -> data, an_n, frame_tick)
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the most significant
//                          enabled non-zero digit are blanked at snapshot time;
//                          digit 0 is never blanked.
// ----------------------------------------------------------------------------
module digit_scan_mux #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int SCAN_HZ     = 1000,
    parameter int NUM_DIGITS  = 8,
    parameter int DEAD_CYCLES = 16
) (
    input logic              clk,
    input logic              rst_n,
    digit_scan_mux_if.slave  bus
);
    localparam int DIV   = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][3:0] digit_vec_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    digit_vec_t            shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
    logic                  init_q;
    logic [3:0]            data_q, data_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_tick_q, frame_tick_d;

    digit_vec_t            in_dig;
    logic [NUM_DIGITS-1:0] in_en;
    logic                  slot_end;
    logic                  frame_end;
    logic                  load;

    assign in_dig = bus.digits_in;

    // Effective enable mask as it will be stored in the shadow register.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        in_en = bus.digit_en;
`ifdef LEADING_ZERO_BLANK_EN
        begin : lzb
            logic seen_nonzero;
            seen_nonzero = 1'b0;
            // Walk from the most significant digit down; zeros met before any
            // enabled non-zero digit are leading zeros. Digit 0 is excluded.
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (bus.digit_en[i]) begin
                    if (in_dig[i] != 4'd0) begin
                        seen_nonzero = 1'b1;
                    end else if (!seen_nonzero) begin
                        in_en[i] = 1'b0;
                    end
                end
            end
        end
`endif
    end

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // First clock after reset release, and every frame boundary.
        load         = !init_q || frame_end;
        shadow_dig_d = shadow_dig_q;
        shadow_en_d  = shadow_en_q;
        if (load) begin
            shadow_dig_d = in_dig;
            shadow_en_d  = in_en;
        end

        // Outputs are derived from next-state so they line up with idx/cnt.
        data_d = shadow_en_d[idx_d] ? shadow_dig_d[idx_d] : 4'hF;
        an_n_d = '1;
        if (cnt_d >= CNT_DEAD && shadow_en_d[idx_d]) begin
            an_n_d = ~(NUM_DIGITS'(1) << idx_d);
        end
        frame_tick_d = frame_end;
    end

    // NOTE: the shadow registers are reset too, so outputs are fully defined
    // (blank) from reset until the first snapshot lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= {NUM_DIGITS{4'hF}};
            shadow_en_q  <= '0;
            init_q       <= 1'b0;
            data_q       <= 4'hF;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_en_q  <= shadow_en_d;
            init_q       <= 1'b1;
            data_q       <= data_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_digit_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_digit_scan_mux
//
// Self-checking bench for digit_scan_mux with DIV=10, NUM_DIGITS=8,
// DEAD_CYCLES=2. The reference model works from elapsed clocks since reset
// release: slot = (k/DIV)%N, position in slot = k%DIV, and the frame's
// snapshot is whatever was driven at the first edge or at each frame boundary.
// ----------------------------------------------------------------------------
module tb_digit_scan_mux;
    localparam int N     = 8;
    localparam int DIV   = 10;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    digit_scan_mux #(
        .CLK_FREQ_HZ(1000),
        .SCAN_HZ    (100),
        .NUM_DIGITS (N),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] drv_dig;
    logic [7:0]  drv_en;
    logic [31:0] snap_dig;
    logic [7:0]  snap_en;
    int          k;
    int          lit[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h k=%0d", tag, obs, exp, k);
        end
    endtask

    // Digits above the most significant enabled non-zero digit are blanked.
    function automatic logic [7:0] eff_en(input logic [31:0] d, input logic [7:0] e);
        logic [7:0] r;
        r = e;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < N; i++)
                if (e[i] && d[4*i +: 4] != 4'd0) top = i;
            for (int i = 0; i < N; i++)
                r[i] = e[i] && (i <= top);
        end
`endif
        return r;
    endfunction

    task automatic drive(input logic [31:0] d, input logic [7:0] e);
        drv_dig       = d;
        drv_en        = e;
        bus.digits_in = d;
        bus.digit_en  = e;
    endtask

    task automatic step();
        logic        snap_edge;
        logic [31:0] pd;
        logic [7:0]  pe;
        int          s, c;
        logic        en;
        logic [3:0]  exp_data;
        logic [7:0]  exp_an;
        snap_edge = (k == 0) || ((k + 1) % FRAME == 0);
        pd = drv_dig;
        pe = eff_en(drv_dig, drv_en);
        @(posedge clk);
        #1;
        k++;
        if (snap_edge) begin
            if (k > 1) begin
                for (int i = 0; i < N; i++) begin
                    check($sformatf("dwell%0d", i), 32'(lit[i]), snap_en[i] ? 32'(DIV - DEAD) : 32'd0);
                    lit[i] = 0;
                end
            end
            snap_dig = pd;
            snap_en  = pe;
        end
        s        = (k / DIV) % N;
        c        = k % DIV;
        en       = snap_en[s];
        exp_data = en ? snap_dig[4*s +: 4] : 4'hF;
        exp_an   = (c < DEAD || !en) ? 8'hFF : ~(8'h01 << s);
        check("data", 32'(bus.data), 32'(exp_data));
        check("an_n", 32'(bus.an_n), 32'(exp_an));
        check("frame_tick", 32'(bus.frame_tick), 32'(k % FRAME == 0));
        check("onehot", 32'($countones(~bus.an_n) <= 1), 32'd1);
        for (int i = 0; i < N; i++)
            if (!bus.an_n[i]) lit[i]++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(bus.data), 32'h0000000F);
        check({tag, "_an_n"}, 32'(bus.an_n), 32'h000000FF);
        check({tag, "_tick"}, 32'(bus.frame_tick), 32'd0);
    endtask

    task automatic to_boundary();
        while ((k + 1) % FRAME != 0) step();
    endtask

    initial begin
        k = 0;
        for (int i = 0; i < N; i++) lit[i] = 0;
        snap_dig = '1;
        snap_en  = '0;

        // Reset state.
        drive(32'h12345678, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan, then a mid-frame change during idx 3.
        repeat (35) step();
        drive(32'h99999999, 8'hFF);
        repeat (125) step();

        // Sparse mask, then everything disabled.
        to_boundary();
        drive($urandom, 8'b0000_0101);
        repeat (FRAME) step();
        drive($urandom, 8'h00);
        repeat (FRAME) step();

        // Random digits and masks with occasional mid-frame changes.
        repeat (4 * FRAME) begin
            if ($urandom_range(0, 19) == 0) drive($urandom, 8'($urandom));
            step();
        end

        // Input change landing exactly on the snapshot edge.
        to_boundary();
        drive($urandom, 8'hFF);
        repeat (FRAME) step();

        // Leading-zero pattern, then all zeros.
        drive(32'h00012034, 8'hFF);
        repeat (FRAME) step();
        drive(32'h00000000, 8'hFF);
        repeat (FRAME) step();

        // Asynchronous reset in the middle of slot 5.
        drive(32'h87654321, 8'hFF);
        while (k % FRAME != 5 * DIV + 6) step();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        k = 0;
        for (int i = 0; i < N; i++) lit[i] = 0;
        drive(32'h12345678, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
